// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle;
// signed ops run on magnitudes and the sign is applied when the result is loaded.
module mult_div_unit (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W     = 32;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       op_q;
  logic [W-1:0]     a_q, b_q;
  logic [CNT_W-1:0] cnt;
  logic [W:0]       acc_hi;
  logic [W-1:0]     acc_lo;

  // op[1] selects divide, op[0] selects signed
  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
    return (sgn && x[W-1]) ? W'(-x) : x;
  endfunction

  logic             accept_c;
  logic             last_c;
  logic [W-1:0]     mag_a_c, mag_b_c;
  logic [W:0]       mul_sum_c;
  logic [W:0]       div_sh_c;
  logic             div_ge_c;
  logic [W:0]       div_sub_c;
  logic [2*W-1:0]   prod_mag_c, prod_c;
  logic [W-1:0]     quot_c, rem_c;
  logic [W-1:0]     res_hi_c, res_lo_c;

  assign accept_c = start && (state != CALC);
  assign last_c   = (state == CALC) && (cnt == CNT_W'(ITER));

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? CALC : IDLE;
      CALC:    state_nxt = last_c ? DONE : CALC;
      DONE:    state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-cycle step datapath and final sign/special-case fix-up
  always_comb begin
    mag_a_c    = mag(a_q, op_q[0]);
    mag_b_c    = mag(b_q, op_q[0]);
    mul_sum_c  = acc_hi + (acc_lo[0] ? {1'b0, mag_a_c} : (W+1)'(0));
    div_sh_c   = {acc_hi[W-1:0], acc_lo[W-1]};
    div_ge_c   = div_sh_c >= {1'b0, mag_b_c};
    div_sub_c  = div_sh_c - {1'b0, mag_b_c};
    prod_mag_c = {acc_hi[W-1:0], acc_lo};
    prod_c     = (op_q[0] && (a_q[W-1] ^ b_q[W-1])) ? (2*W)'(-prod_mag_c) : prod_mag_c;
    quot_c     = (op_q[0] && (a_q[W-1] ^ b_q[W-1])) ? W'(-acc_lo) : acc_lo;
    rem_c      = (op_q[0] && a_q[W-1]) ? W'(-acc_hi[W-1:0]) : acc_hi[W-1:0];
    res_hi_c   = prod_c[2*W-1:W];
    res_lo_c   = prod_c[W-1:0];
    if (op_q[1]) begin
      if (b_q == '0) begin
        res_hi_c = a_q;
        res_lo_c = '1;
      end else begin
        res_hi_c = rem_c;
        res_lo_c = quot_c;
      end
    end
  end

  // State, flags, operand latches, iteration and HI/LO registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == CALC);
      done  <= (state_nxt == DONE);
      if (accept_c) begin
        op_q   <= op;
        a_q    <= rs_data;
        b_q    <= rt_data;
        cnt    <= '0;
        acc_hi <= '0;
        acc_lo <= op[1] ? mag(rs_data, op[0]) : mag(rt_data, op[0]);
      end else if (state == CALC) begin
        if (last_c) begin
          hi <= res_hi_c;
          lo <= res_lo_c;
        end else begin
          cnt <= cnt + CNT_W'(1);
          if (op_q[1]) begin
            acc_hi <= div_ge_c ? div_sub_c : div_sh_c;
            acc_lo <= {acc_lo[W-2:0], div_ge_c};
          end else begin
            acc_hi <= {1'b0, mul_sum_c[W:1]};
            acc_lo <= {mul_sum_c[0], acc_lo[W-1:1]};
          end
        end
      end else begin
        if (hi_wr) hi <= wdata;
        if (lo_wr) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected {hi,lo},
// a negedge monitor pops and compares whenever done is seen.
module tb_mult_div_unit;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        hi_wr, lo_wr;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  mult_div_unit dut (
    .CLK(CLK), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare each done pulse against the oldest expected result
  always @(negedge CLK) begin
    if (!reset && done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got hi=%h lo=%h with no result pending", hi, lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({hi, lo} !== e) begin
          bad++;
          $display("FAIL result: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, e[63:32], e[31:0]);
        end
      end
    end
  end

  // Called at a negedge; start is sampled at the next posedge
  task automatic drive_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic push, input logic [31:0] ehi, input logic [31:0] elo);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    if (push) exp_q.push_back({ehi, elo});
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  // Counts busy cycles up to the negedge where done is seen
  task automatic wait_done(input string name, input int exp_busy);
    int n = 0;
    int guard = 0;
    @(negedge CLK);
    while (!done && guard < 100) begin
      if (busy) n++;
      guard++;
      @(negedge CLK);
    end
    if (guard >= 100) check_int({name, "_timeout"}, guard, 0);
    check_int({name, "_busy_cycles"}, n, exp_busy);
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a, b, ehi, elo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_done;
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    hi_wr = 1'b0; lo_wr = 1'b0; wdata = '0;

    vecs[0] = '{2'b01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2] = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[3] = '{2'b10, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[4] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[5] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[6] = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[7] = '{2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check32("rst_busy", 32'(busy), 32'd0);
    check32("rst_done", 32'(done), 32'd0);
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge CLK);

    // MULTU max x max, latency and single done pulse
    drive_start(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001);
    wait_done("multu_max", 33);
    @(negedge CLK);
    check32("multu_done_once", 32'(done), 32'd0);
    check32("multu_idle_busy", 32'(busy), 32'd0);
    check32("multu_hold_hi", hi, 32'hFFFFFFFE);

    // Directed signed/unsigned vectors incl. divide by zero and overflow case
    foreach (vecs[i]) begin
      drive_start(vecs[i].o, vecs[i].a, vecs[i].b, 1'b1, vecs[i].ehi, vecs[i].elo);
      wait_done($sformatf("vec%0d", i), 33);
      @(negedge CLK);
    end

    // Start during CALC with changed operands is ignored
    drive_start(2'b00, 32'd1000, 32'd3, 1'b1, 32'd0, 32'd3000);
    repeat (5) @(negedge CLK);
    start = 1'b1; op = 2'b10; rs_data = 32'd5; rt_data = 32'd5;
    @(posedge CLK);
    #1 start = 1'b0; rs_data = 32'hAAAAAAAA; rt_data = 32'h55555555;
    wait_done("ignore_start", 28);
    @(negedge CLK);

    // Start held in the DONE cycle begins a second operation immediately
    drive_start(2'b10, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    wait_done("b2b_first", 33);
    drive_start(2'b01, 32'hFFFFFFFD, 32'd7, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB);
    @(negedge CLK);
    check32("b2b_busy", 32'(busy), 32'd1);
    wait_done("b2b_second", 32);
    @(negedge CLK);

    // HI/LO moves in IDLE
    hi_wr = 1'b1; wdata = 32'h12345678;
    @(posedge CLK);
    #1 hi_wr = 1'b0;
    @(negedge CLK);
    check32("mthi", hi, 32'h12345678);
    lo_wr = 1'b1; wdata = 32'hDEADBEEF;
    @(posedge CLK);
    #1 lo_wr = 1'b0;
    @(negedge CLK);
    check32("mtlo", lo, 32'hDEADBEEF);
    check32("mtlo_hi_kept", hi, 32'h12345678);
    hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'hCAFEF00D;
    @(posedge CLK);
    #1 begin hi_wr = 1'b0; lo_wr = 1'b0; end
    @(negedge CLK);
    check32("mt_both_hi", hi, 32'hCAFEF00D);
    check32("mt_both_lo", lo, 32'hCAFEF00D);

    // Moves while busy are ignored
    drive_start(2'b10, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    @(negedge CLK);
    hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'h00000055;
    @(posedge CLK);
    #1 begin hi_wr = 1'b0; lo_wr = 1'b0; end
    @(negedge CLK);
    check32("busy_mtlo", lo, 32'hCAFEF00D);
    check32("busy_mthi", hi, 32'hCAFEF00D);
    wait_done("busy_move_op", 31);
    @(negedge CLK);

    // Start and move in the same cycle: the move is dropped
    hi_wr = 1'b1; wdata = 32'h00000077;
    drive_start(2'b00, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6);
    hi_wr = 1'b0;
    @(negedge CLK);
    check32("start_wins_hi", hi, 32'd2);
    wait_done("start_wins_op", 32);
    @(negedge CLK);

    // Reset 10 cycles into a MULTU aborts it without a result
    drive_start(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd0);
    repeat (10) @(negedge CLK);
    reset = 1'b1;
    @(posedge CLK);
    #1 reset = 1'b0;
    @(negedge CLK);
    check32("abort_busy", 32'(busy), 32'd0);
    check32("abort_done", 32'(done), 32'd0);
    check32("abort_hi", hi, 32'd0);
    check32("abort_lo", lo, 32'd0);
    cnt_done = 0;
    repeat (40) begin
      @(negedge CLK);
      if (done) cnt_done++;
    end
    check_int("abort_no_done", cnt_done, 0);

    check_int("pending_results", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have no parameters; operand width fixed at 32 bits, iteration count fixed at 32.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 start  input  1  request to begin the operation selected by op, using rs_data/rt_data.
REQ-005 op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 rs_data  input  32  register-file read port 1: multiplicand or dividend.
REQ-007 rt_data  input  32  register-file read port 2: multiplier or divisor.
REQ-008 hi_wr  input  1  MTHI: write wdata into HI.
REQ-009 lo_wr  input  1  MTLO: write wdata into LO.
REQ-010 wdata  input  32  data for hi_wr/lo_wr.
REQ-011 busy  output  1  operation in progress; start, hi_wr and lo_wr ignored.
REQ-012 done  output  1  one-cycle pulse, coincident with the first cycle HI/LO hold the new result.
REQ-013 hi  output  32  HI register (product high word / remainder).
REQ-014 lo  output  32  LO register (product low word / quotient).

Function
REQ-015 SHALL implement FSM states IDLE, CALC and DONE.
REQ-016 IDLE/DONE with start=1 at an edge: latch op, rs_data and rt_data; clear the iteration counter; go to CALC.
REQ-017 CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; after 32 steps go to DONE and load the result into hi/lo on that same edge.
REQ-018 DONE lasts one cycle with done=1; it returns to IDLE unless start=1, which is accepted per REQ-016.
REQ-019 Latency: with start sampled at edge k, busy=1 from after edge k until edge k+33. At edge k+33, hi/lo take the result and done=1 for that cycle.
REQ-020 busy SHALL equal 1 exactly in CALC; done SHALL equal 1 exactly in DONE.
REQ-021 start while busy=1 SHALL be ignored, with no queuing; latched operands SHALL NOT follow input changes during CALC.
REQ-022 Signed ops: operate on magnitudes, then apply sign. Product is negative iff operand signs differ; quotient is negative iff signs differ; remainder takes the dividend's sign.
REQ-023 MULT/MULTU: {hi,lo} = full 64-bit product.
REQ-024 DIV/DIVU: lo = quotient, truncated toward zero; hi = remainder.
REQ-025 Divide by zero (rt_data=0, either div op): hi = rs_data, lo = 32'hFFFFFFFF.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0, with no fault.
REQ-027 hi_wr/lo_wr in IDLE or DONE: write wdata to hi/lo at the next edge. Both may be asserted together, in which case both are written.
REQ-028 hi_wr/lo_wr while busy=1 SHALL be ignored.
REQ-029 start together with hi_wr/lo_wr in the same cycle: start wins and the move is dropped.
REQ-030 hi/lo SHALL hold their value at all times except result load (REQ-017), moves (REQ-027) and reset.

Reset
REQ-031 reset=1 at an edge: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, latched operands=0.
REQ-032 reset SHALL take priority over start, hi_wr, lo_wr and any in-progress operation; an aborted operation SHALL NOT write hi/lo.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy for 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
REQ-034 MULT -3 (0xFFFFFFFD) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2.
REQ-035 DIVU 5 / 0 -> hi=5, lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 start pulsed again 5 cycles into an operation, with changed operands -> ignored, and the first result is unaffected. start held high in the DONE cycle -> second operation begins, busy=1 next cycle.
REQ-037 reset asserted 10 cycles into a MULTU -> next cycle busy=0, done=0, hi=lo=0, and no done pulse follows.
REQ-038 hi_wr with wdata=0x12345678 in IDLE -> hi=0x12345678 next cycle. lo_wr during CALC -> lo unchanged.
